// File: rtl/conv_tile_sequencer.sv
// Address/strobe sequencer for the tiled convolution engine: walks a TILE_R x TILE_C
// output tile over a K x K kernel, then optionally drains the accumulators to the output buffer.
module conv_tile_sequencer #(
  parameter int TILE_R   = 8,
  parameter int TILE_C   = 8,
  parameter int K        = 3,
  parameter int STRIDE   = 1,
  parameter int PIPE_DLY = 2,
  parameter int AI_W     = 13,
  parameter int AW_W     = 10,
  parameter int AF_W     = 12
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            init,
  input  logic            finish,
  input  logic            stall,
  output logic [AI_W-1:0] addr_i,
  output logic [AW_W-1:0] addr_w,
  output logic [AF_W-1:0] rd_addr_f,
  output logic            issue_vld,
  output logic [AF_W-1:0] wr_addr_f,
  output logic [3:0]      we_f,
  output logic            select,
  output logic [AF_W-1:0] wr_addr_out,
  output logic [3:0]      we_out,
  output logic            done
);
  localparam int IN_C = (TILE_C-1)*STRIDE + K;
  localparam int TRW  = (TILE_R > 1) ? $clog2(TILE_R) : 1;
  localparam int TCW  = (TILE_C > 1) ? $clog2(TILE_C) : 1;
  localparam int KW   = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;
  state_t state;

  logic [TRW-1:0] tr;
  logic [TCW-1:0] tc;
  logic [KW-1:0]  ki, kj;

  // stage 0 is the issue register; we_f comes out of stage PIPE_DLY, we_out one later
  logic [AF_W-1:0]      addr_pipe [PIPE_DLY+1:0];
  logic [PIPE_DLY:0]    vld_pipe;
  logic [PIPE_DLY:0]    sel_pipe;
  logic [PIPE_DLY+1:0]  drn_pipe;

  logic tc_last, tr_last, kj_last, ki_last, tile_last, accum_last, issuing, run_last;
  logic in_flight;
  logic [AI_W-1:0] ai_c;
  logic [AW_W-1:0] aw_c;
  logic [AF_W-1:0] af_c;

  assign tc_last    = (tc == TCW'(TILE_C-1));
  assign tr_last    = (tr == TRW'(TILE_R-1));
  assign kj_last    = (kj == KW'(K-1));
  assign ki_last    = (ki == KW'(K-1));
  assign tile_last  = tc_last && tr_last;
  assign accum_last = tile_last && kj_last && ki_last;
  assign issuing    = ((state == ACCUM) || (state == DRAIN)) && !stall;
  assign run_last   = (state == ACCUM) ? accum_last : tile_last;

  assign ai_c = AI_W'(4*(IN_C*(int'(tr)*STRIDE + int'(ki)) + int'(tc)*STRIDE + int'(kj)));
  assign aw_c = AW_W'(4*(K*int'(ki) + int'(kj)));
  assign af_c = AF_W'(4*(TILE_C*int'(tr) + int'(tc)));

  // strobes that will still surface on we_f/we_out after this cycle
  assign in_flight = (|vld_pipe[PIPE_DLY-1:0]) || (|drn_pipe[PIPE_DLY:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tr       <= '0;
      tc       <= '0;
      ki       <= '0;
      kj       <= '0;
      addr_i   <= '0;
      addr_w   <= '0;
      vld_pipe <= '0;
      sel_pipe <= '0;
      drn_pipe <= '0;
      done     <= 1'b0;
      for (int s = 0; s <= PIPE_DLY+1; s++) addr_pipe[s] <= '0;
    end else begin
      for (int s = 1; s <= PIPE_DLY+1; s++) addr_pipe[s] <= addr_pipe[s-1];
      vld_pipe[PIPE_DLY:1]   <= vld_pipe[PIPE_DLY-1:0];
      sel_pipe[PIPE_DLY:1]   <= sel_pipe[PIPE_DLY-1:0];
      drn_pipe[PIPE_DLY+1:1] <= drn_pipe[PIPE_DLY:0];
      vld_pipe[0] <= 1'b0;
      sel_pipe[0] <= 1'b0;
      drn_pipe[0] <= 1'b0;

      case (state)
        IDLE:  if (start) state <= ACCUM;
        ACCUM: if (!stall) begin
          vld_pipe[0]  <= 1'b1;
          sel_pipe[0]  <= init && (ki == '0) && (kj == '0);
          addr_i       <= ai_c;
          addr_w       <= aw_c;
          addr_pipe[0] <= af_c;
          if (accum_last) state <= finish ? DRAIN : DONE;
        end
        DRAIN: begin
          addr_i <= '0;
          addr_w <= '0;
          if (!stall) begin
            drn_pipe[0]  <= 1'b1;
            addr_pipe[0] <= af_c;
            if (tile_last) state <= DONE;
          end
        end
        DONE:  if (!start && done) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (issuing) begin
        if (tc_last) begin
          tc <= '0;
          if (tr_last) begin
            tr <= '0;
            if (kj_last) begin
              kj <= '0;
              ki <= ki + 1'b1;
            end else kj <= kj + 1'b1;
          end else tr <= tr + 1'b1;
        end else tc <= tc + 1'b1;
        if (run_last) begin
          tr <= '0;
          tc <= '0;
          ki <= '0;
          kj <= '0;
        end
      end

      done <= (state == DONE) && !(done && !start) && !in_flight;
    end
  end

  assign rd_addr_f   = addr_pipe[0];
  assign issue_vld   = vld_pipe[0] || drn_pipe[0];
  assign wr_addr_f   = addr_pipe[PIPE_DLY];
  assign we_f        = {4{vld_pipe[PIPE_DLY]}};
  assign select      = sel_pipe[PIPE_DLY];
  assign wr_addr_out = addr_pipe[PIPE_DLY+1];
  assign we_out      = {4{drn_pipe[PIPE_DLY+1]}};
endmodule

// File: tb/tb_conv_tile_sequencer.sv
// Bench for conv_tile_sequencer: event logs per run compared against a loop-nest reference model.
module tb_conv_tile_sequencer;
  localparam int TR = 8, TC = 8, KK = 3, PD = 2;
  localparam int N_ACC = TR*TC*KK*KK, N_DRN = TR*TC;

  logic clk = 1'b0;
  logic reset, start, init, finish, stall;
  logic [12:0] addr_i;  logic [9:0] addr_w;  logic [11:0] rd_addr_f, wr_addr_f, wr_addr_out;
  logic issue_vld, select, done;  logic [3:0] we_f, we_out;
  logic [12:0] b_addr_i; logic [9:0] b_addr_w; logic [11:0] b_rd, b_wrf, b_wro;
  logic b_vld, b_sel, b_done; logic [3:0] b_wef, b_weo;

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  conv_tile_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .init(init), .finish(finish), .stall(stall),
    .addr_i(addr_i), .addr_w(addr_w), .rd_addr_f(rd_addr_f), .issue_vld(issue_vld),
    .wr_addr_f(wr_addr_f), .we_f(we_f), .select(select), .wr_addr_out(wr_addr_out),
    .we_out(we_out), .done(done));

  conv_tile_sequencer #(.STRIDE(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .init(init), .finish(finish), .stall(stall),
    .addr_i(b_addr_i), .addr_w(b_addr_w), .rd_addr_f(b_rd), .issue_vld(b_vld),
    .wr_addr_f(b_wrf), .we_f(b_wef), .select(b_sel), .wr_addr_out(b_wro),
    .we_out(b_weo), .done(b_done));

  int errors = 0, checks = 0;
  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // reference: issue order from the loop nest (i outermost, tc innermost), then the drain pass
  int exp_ai[$], exp_aw[$], exp_af[$], exp_sel[$], exp2_ai[$];
  task automatic build_model(input bit iv, input bit fv);
    exp_ai = {}; exp_aw = {}; exp_af = {}; exp_sel = {}; exp2_ai = {};
    for (int i = 0; i < KK; i++)
      for (int j = 0; j < KK; j++)
        for (int r = 0; r < TR; r++)
          for (int c = 0; c < TC; c++) begin
            exp_ai.push_back(4*(((TC-1)*1+KK)*(r*1+i) + c*1+j));
            exp2_ai.push_back(4*(((TC-1)*2+KK)*(r*2+i) + c*2+j));
            exp_aw.push_back(4*(KK*i+j));
            exp_af.push_back(4*(TC*r+c));
            exp_sel.push_back((iv && i == 0 && j == 0) ? 1 : 0);
          end
    if (fv)
      for (int r = 0; r < TR; r++)
        for (int c = 0; c < TC; c++) begin
          exp_ai.push_back(0); exp2_ai.push_back(0); exp_aw.push_back(0);
          exp_af.push_back(4*(TC*r+c)); exp_sel.push_back(0);
        end
  endtask

  int iss_cyc[$], iss_ai[$], iss_aw[$], iss_af[$], b_ai[$];
  int wf_cyc[$], wf_addr[$], wf_we[$], wf_sel[$], wo_cyc[$], wo_addr[$], wo_we[$];

  task automatic run(input string nm, input bit iv, input bit fv, input int smode);
    int done_cyc, bad, first, n_iss, hold_ok;
    build_model(iv, fv);
    iss_cyc = {}; iss_ai = {}; iss_aw = {}; iss_af = {}; b_ai = {};
    wf_cyc = {}; wf_addr = {}; wf_we = {}; wf_sel = {}; wo_cyc = {}; wo_addr = {}; wo_we = {};
    init = iv; finish = fv; stall = 1'b0; start = 1'b1;
    done_cyc = -1;
    for (int n = 0; n < 4000 && done_cyc < 0; n++) begin
      @(negedge clk);
      if (issue_vld) begin
        iss_cyc.push_back(cyc); iss_ai.push_back(int'(addr_i));
        iss_aw.push_back(int'(addr_w)); iss_af.push_back(int'(rd_addr_f));
      end
      if (b_vld) b_ai.push_back(int'(b_addr_i));
      if (we_f != 0) begin
        wf_cyc.push_back(cyc); wf_addr.push_back(int'(wr_addr_f));
        wf_we.push_back(int'(we_f)); wf_sel.push_back(int'(select));
      end
      if (we_out != 0) begin
        wo_cyc.push_back(cyc); wo_addr.push_back(int'(wr_addr_out)); wo_we.push_back(int'(we_out));
      end
      if (done) done_cyc = cyc;
      stall = (smode == 1) ? (n % 3 == 2) : (smode == 2) ? ($urandom_range(3) == 0) : 1'b0;
    end
    stall = 1'b0;
    check({nm, "/done_seen"}, done_cyc >= 0, 1);
    n_iss = N_ACC + (fv ? N_DRN : 0);
    check({nm, "/issue_cnt"}, iss_cyc.size(), n_iss);

    bad = 0; first = -1;
    for (int k = 0; k < iss_cyc.size() && k < n_iss; k++)
      if (iss_ai[k] != exp_ai[k] || iss_aw[k] != exp_aw[k] || iss_af[k] != exp_af[k]) begin
        bad++; if (first < 0) first = k;
      end
    check({nm, "/issue_order_bad"}, bad, 0);
    if (first >= 0) check({nm, "/issue_first_bad_ai"}, iss_ai[first], exp_ai[first]);

    check({nm, "/we_f_cnt"}, wf_cyc.size(), N_ACC);
    bad = 0;
    for (int k = 0; k < wf_cyc.size() && k < N_ACC && k < iss_cyc.size(); k++)
      if (wf_cyc[k] != iss_cyc[k] + PD || wf_addr[k] != exp_af[k] || wf_we[k] != 15) bad++;
    check({nm, "/we_f_timing_bad"}, bad, 0);
    bad = 0;
    for (int k = 0; k < wf_cyc.size() && k < N_ACC; k++)
      if (wf_sel[k] != exp_sel[k]) bad++;
    check({nm, "/select_bad"}, bad, 0);

    check({nm, "/we_out_cnt"}, wo_cyc.size(), fv ? N_DRN : 0);
    bad = 0;
    for (int k = 0; k < wo_cyc.size() && N_ACC + k < iss_cyc.size(); k++)
      if (wo_cyc[k] != iss_cyc[N_ACC+k] + PD + 1 || wo_addr[k] != 4*k || wo_we[k] != 15) bad++;
    check({nm, "/we_out_bad"}, bad, 0);

    if (iss_cyc.size() > 0) begin
      if (!fv) check({nm, "/done_lat"}, done_cyc - iss_cyc[iss_cyc.size()-1], PD + 1);
      else if (wo_cyc.size() > 0)
        check({nm, "/done_after_we_out"},
              (done_cyc > wo_cyc[wo_cyc.size()-1]) && (done_cyc <= wo_cyc[wo_cyc.size()-1] + 2), 1);
    end

    bad = 0;
    for (int k = 0; k < b_ai.size() && k < n_iss; k++) if (b_ai[k] != exp2_ai[k]) bad++;
    check({nm, "/s2_cnt"}, b_ai.size(), n_iss);
    check({nm, "/s2_order_bad"}, bad, 0);

    // start still high: done must hold with no restart
    hold_ok = 1;
    repeat (3) begin
      @(negedge clk);
      if (!done || issue_vld || we_f != 0 || we_out != 0) hold_ok = 0;
    end
    check({nm, "/done_hold_no_restart"}, hold_ok, 1);
    start = 1'b0;
    @(negedge clk);
    check({nm, "/done_drop"}, done, 0);
    @(negedge clk);
    check({nm, "/idle_quiet"}, issue_vld, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; init = 1'b0; finish = 1'b0; stall = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_addrs", {addr_i, addr_w, rd_addr_f, wr_addr_f, wr_addr_out}, 0);
    check("rst_ctrl", {issue_vld, we_f, select, we_out, done}, 0);
    reset = 1'b0;

    run("t1", 1'b0, 1'b0, 0);
    check("t1/tuple0_ai", iss_ai[0], 0);
    check("t1/tuple1_ai", iss_ai[1], 4);
    check("t1/tuple8_ai", iss_ai[8], 40);
    check("t1/last_ai", iss_ai[N_ACC-1], 396);
    check("t1/last_aw", iss_aw[N_ACC-1], 32);
    check("t1/s2_tuple_284", b_ai[((2*KK + 1)*TR + 1)*TC + 1], 284);

    run("t2", 1'b1, 1'b0, 0);
    run("t3", 1'b0, 1'b1, 0);
    run("t5", 1'b0, 1'b0, 1);
    run("t5d", 1'b1, 1'b1, 1);
    repeat (2) run("rnd", 1'($urandom_range(1)), 1'($urandom_range(1)), 2);

    // reset in the middle of ACCUM, then restart from tuple 0
    init = 1'b0; finish = 1'b0; start = 1'b1;
    repeat (100) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t6/rst_addrs", {addr_i, addr_w, rd_addr_f, wr_addr_f, wr_addr_out}, 0);
    check("t6/rst_ctrl", {issue_vld, we_f, select, we_out, done}, 0);
    reset = 1'b0;
    run("t6", 1'b0, 1'b0, 0);
    check("t6/tuple0_ai", iss_ai[0], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
